// File: rtl/dp_pkg.sv
// Shared types and instruction-field geometry for the datapath instruction sequencer.
// Instruction layout, MSB first: {cond, op, rd, rs1, rs2}.
package dp_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXEC = 3'd1,
    WB   = 3'd2,
    RESP = 3'd3,
    HALT = 3'd4
  } dp_state_t;

  // Field positions for an arbitrary address/op width
  function automatic int rs2_lsb(input int addr_w);
    return 0 * addr_w;
  endfunction

  function automatic int rs1_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int rd_lsb(input int addr_w);
    return 2 * addr_w;
  endfunction

  function automatic int op_lsb(input int addr_w);
    return 3 * addr_w;
  endfunction

  function automatic int cond_bit(input int addr_w, input int op_w);
    return 3 * addr_w + op_w;
  endfunction

  // Field positions for the default geometry (ADDR_W=2, OP_W=3)
  localparam int RS2_LSB  = 0;
  localparam int RS1_LSB  = 2;
  localparam int RD_LSB   = 4;
  localparam int OP_LSB   = 6;
  localparam int COND_BIT = 9;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

endpackage

// File: rtl/dp_sequencer.sv
// Issues one register-register instruction at a time to the regfile/ALU datapath
// (EXEC then WB), with conditional write, halt-on-overflow and a retire counter.
module dp_sequencer
  import dp_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 2,
  parameter int OP_W        = 3,
  parameter int CNT_W       = 16,
  parameter bit HALT_ON_OVF = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OP_W+3*ADDR_W:0]  in_instr,
  input  logic                    resume,
  input  logic                    clear_sticky,
  output logic                    wr,
  output logic [OP_W-1:0]         ALUControl,
  output logic [ADDR_W-1:0]       addr1,
  output logic [ADDR_W-1:0]       addr2,
  output logic [ADDR_W-1:0]       addr3,
  input  logic [DATA_W-1:0]       Result,
  input  logic                    Zero,
  input  logic                    Overflow,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       res_data,
  output logic                    res_zero,
  output logic                    res_ovf,
  output logic                    res_squashed,
  output logic                    ovf_sticky,
  output logic [CNT_W-1:0]        retired,
  output logic                    halted
);

  localparam int INSTR_W = 1 + OP_W + 3 * ADDR_W;
  localparam int C_BIT   = cond_bit(ADDR_W, OP_W);
  localparam int O_LSB   = op_lsb(ADDR_W);
  localparam int D_LSB   = rd_lsb(ADDR_W);
  localparam int S1_LSB  = rs1_lsb(ADDR_W);
  localparam int S2_LSB  = rs2_lsb(ADDR_W);
  localparam logic HALT_EN = HALT_ON_OVF;

  dp_state_t            state_reg, state_next;
  logic [INSTR_W-1:0]   instr_reg;
  logic [DATA_W-1:0]    res_data_reg;
  logic                 res_zero_reg;
  logic                 res_ovf_reg;
  logic                 squash_reg;
  logic                 squash_next;
  logic                 sticky_reg;
  logic                 last_zero_reg;
  logic [CNT_W-1:0]     retired_reg;

  // Condition is judged against the Zero of the previous instruction, not this one
  assign squash_next = (instr_reg[C_BIT] & ~last_zero_reg) | (HALT_EN & Overflow);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    wr         = 1'b0;
    out_valid  = 1'b0;
    halted     = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = EXEC;
      end
      EXEC: state_next = WB;
      WB: begin
        wr         = ~squash_reg;
        state_next = RESP;
      end
      RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_next = (HALT_EN & res_ovf_reg) ? HALT : IDLE;
      end
      HALT: begin
        halted = 1'b1;
        if (resume) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_reg     <= '0;
      res_data_reg  <= '0;
      res_zero_reg  <= 1'b0;
      res_ovf_reg   <= 1'b0;
      squash_reg    <= 1'b0;
      sticky_reg    <= 1'b0;
      last_zero_reg <= 1'b0;
      retired_reg   <= '0;
    end else begin
      if (state_reg == IDLE && in_valid) begin
        instr_reg <= in_instr;
      end
      if (state_reg == EXEC) begin
        res_data_reg <= Result;
        res_zero_reg <= Zero;
        res_ovf_reg  <= Overflow;
        squash_reg   <= squash_next;
      end
      // A new overflow outranks a simultaneous clear request
      if (state_reg == EXEC && Overflow) begin
        sticky_reg <= 1'b1;
      end else if (clear_sticky) begin
        sticky_reg <= 1'b0;
      end
      if (state_reg == WB) begin
        last_zero_reg <= res_zero_reg;
        if (!squash_reg) retired_reg <= retired_reg + CNT_W'(1);
      end
    end
  end

  // Operand/destination fields stay on the datapath from EXEC through RESP
  assign ALUControl   = instr_reg[O_LSB +: OP_W];
  assign addr1        = instr_reg[S1_LSB +: ADDR_W];
  assign addr2        = instr_reg[S2_LSB +: ADDR_W];
  assign addr3        = instr_reg[D_LSB +: ADDR_W];
  assign res_data     = res_data_reg;
  assign res_zero     = res_zero_reg;
  assign res_ovf      = res_ovf_reg;
  assign res_squashed = squash_reg;
  assign ovf_sticky   = sticky_reg;
  assign retired      = retired_reg;

endmodule
